// File: rtl/req_seq_pkg.sv
// Shared types and defaults for the request sequencer.
package req_seq_pkg;

    localparam int TAG_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        DONE
    } req_seq_state_t;

endpackage

// File: rtl/req_seq_fifo.sv
// Command tag FIFO: power-of-two depth, pointer-with-wrap-bit full/empty,
// head entry presented on data. Push while full and pop while empty are ignored.
module req_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [TAG_W-1:0] din,
    input  logic             pop,
    output logic [TAG_W-1:0] data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Occupancy flags and qualified push/pop.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        data    = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/req_sequencer.sv
// Request sequencer: queues command tags, issues a one-cycle req per tag,
// waits for ack low then high (each phase bounded by TIMEOUT cycles), and
// reports done_valid or timeout with the tag.
// Optional: define REQ_SEQUENCER_SVA_EN to compile in concurrent properties.
module req_sequencer
    import req_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             req,
    input  logic             ack,
    output logic             done_valid,
    output logic [TAG_W-1:0] done_tag,
    output logic             timeout,
    output logic             busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    req_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [TAG_W-1:0] fifo_data;

    // Ready drops during reset so nothing is accepted while the FIFO is held empty.
    assign cmd_ready = ~fifo_full & ~rst;

    req_seq_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid & cmd_ready),
        .din   (cmd_tag),
        .pop   (fifo_pop),
        .data  (fifo_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state and Moore-style outputs; an ack transition wins over a
    // counter expiring in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tag_d      = tag_q;
        fifo_pop   = 1'b0;
        req        = 1'b0;
        done_valid = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    tag_d    = fifo_data;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                req     = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!ack) begin
                    cnt_d   = '0;
                    state_d = WAIT_HIGH;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (ack) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done_tag = tag_q;

    // State, wait counter and held tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

`ifdef REQ_SEQUENCER_SVA_EN
    // req is a single pulse and the block stays busy afterwards.
    a_req_pulse: assert property (@(posedge clk) disable iff (rst)
        req |=> (busy & ~req));

    // Downstream returns ack high within two cycles of dropping it.
    m_ack_return: assume property (@(posedge clk) disable iff (rst)
        $fell(ack) |-> ##[1:2] ack);

    // A request that completes successfully.
    c_req_done: cover property (@(posedge clk) disable iff (rst)
        req ##[1:$] done_valid);
`endif

endmodule
